fwd_scoreboard_unit: RTL and testbench

//  Parametrised operand-forwarding and hazard unit for the pipelined core; sits beside the RR stage.

---
 rtl/fwd_scoreboard_unit.sv | 193 +++++++++++++++++++
 tb/tb_fwd_scoreboard_unit.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard_unit.sv
// fwd_scoreboard_unit
// Operand forwarding and hazard detection for the RR stage. Each read port
// is resolved against the EX, MEM and WB writers and a short retire buffer
// of recent register-file writes. A freeze is raised whenever a needed value
// is not produced yet. A small FSM tracks the length of the current stall and
// flags stalls that run too long. Saturating counters record stall and
// forwarding activity.
module fwd_scoreboard_unit #(
  parameter int DATA_W    = 16,
  parameter int NREGS     = 8,
  parameter int NRD       = 2,
  parameter int RET_DEPTH = 2,
  parameter int MAX_STALL = 15,
  parameter int ZERO_REG  = 0,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NRD-1:0]        rd_en,
  input  logic [NRD*AW-1:0]     rd_addr,
  input  logic                  ex_wr_en,
  input  logic [AW-1:0]         ex_dest,
  input  logic [DATA_W-1:0]     ex_data,
  input  logic                  ex_vld,
  input  logic                  mem_wr_en,
  input  logic [AW-1:0]         mem_dest,
  input  logic [DATA_W-1:0]     mem_data,
  input  logic                  mem_vld,
  input  logic                  wb_wr_en,
  input  logic [AW-1:0]         wb_dest,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  clr_stats,
  output logic [NRD*DATA_W-1:0] fwd_data,
  output logic [NRD-1:0]        fwd_en,
  output logic                  freeze,
  output logic                  stall_timeout,
  output logic [15:0]           stall_cycles,
  output logic [15:0]           fwd_events
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  // Retire buffer: entry 0 holds the newest WB write.
  logic [RET_DEPTH-1:0] ret_vld_q;
  logic [AW-1:0]        ret_dest_q [RET_DEPTH];
  logic [DATA_W-1:0]    ret_data_q [RET_DEPTH];

  logic [NRD-1:0] hazard;

  state_e       state_q, state_d;
  logic [7:0]   stall_cnt_q, stall_cnt_d;
  logic         stall_timeout_q, stall_timeout_d;
  logic [8:0]   stall_cnt_inc;

  logic [15:0]  stall_cycles_q;
  logic [15:0]  fwd_events_q;

  // Shift each WB write into the retire buffer; freeze never blocks retirement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the buffer is a handful of flops, so data is reset along with
      // the valid bits; this keeps X out of the forwarding muxes after reset.
      ret_vld_q <= '0;
      for (int k = 0; k < RET_DEPTH; k++) begin
        ret_dest_q[k] <= '0;
        ret_data_q[k] <= '0;
      end
    end else if (wb_wr_en) begin
      // NOTE: non-blocking assignments let every entry read its neighbour's
      // pre-edge value, which is what makes this a shift rather than a smear.
      ret_vld_q[0]  <= 1'b1;
      ret_dest_q[0] <= wb_dest;
      ret_data_q[0] <= wb_data;
      for (int k = 1; k < RET_DEPTH; k++) begin
        ret_vld_q[k]  <= ret_vld_q[k-1];
        ret_dest_q[k] <= ret_dest_q[k-1];
        ret_data_q[k] <= ret_data_q[k-1];
      end
    end
  end

  // Per-port lookup, youngest writer first; an unfinished EX/MEM value is a hazard.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // through the priority chain leaves a value unassigned (no latches).
    fwd_en   = '0;
    fwd_data = '0;
    hazard   = '0;
    for (int i = 0; i < NRD; i++) begin
      if (rd_en[i] && !((ZERO_REG != 0) && (rd_addr[i*AW +: AW] == '0))) begin
        if (ex_wr_en && (ex_dest == rd_addr[i*AW +: AW])) begin
          if (ex_vld) begin
            fwd_en[i]                    = 1'b1;
            fwd_data[i*DATA_W +: DATA_W] = ex_data;
          end else begin
            hazard[i] = 1'b1;
          end
        end else if (mem_wr_en && (mem_dest == rd_addr[i*AW +: AW])) begin
          if (mem_vld) begin
            fwd_en[i]                    = 1'b1;
            fwd_data[i*DATA_W +: DATA_W] = mem_data;
          end else begin
            hazard[i] = 1'b1;
          end
        end else if (wb_wr_en && (wb_dest == rd_addr[i*AW +: AW])) begin
          fwd_en[i]                    = 1'b1;
          fwd_data[i*DATA_W +: DATA_W] = wb_data;
        end else begin
          // Walk oldest to newest so the newest matching entry is the one left.
          for (int k = RET_DEPTH - 1; k >= 0; k--) begin
            if (ret_vld_q[k] && (ret_dest_q[k] == rd_addr[i*AW +: AW])) begin
              fwd_en[i]                    = 1'b1;
              fwd_data[i*DATA_W +: DATA_W] = ret_data_q[k];
            end
          end
        end
      end
    end
  end

  assign freeze = |hazard;

  // Stall FSM state, stall length and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_RUN;
      stall_cnt_q     <= '0;
      stall_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      stall_cnt_q     <= stall_cnt_d;
      stall_timeout_q <= stall_timeout_d;
    end
  end

  assign stall_cnt_inc = {1'b0, stall_cnt_q} + 9'd1;

  // Next-state logic: count consecutive freeze cycles, flag when MAX_STALL is reached.
  always_comb begin
    state_d         = state_q;
    stall_cnt_d     = stall_cnt_q;
    stall_timeout_d = stall_timeout_q;
    case (state_q)
      ST_RUN: begin
        if (freeze) begin
          state_d     = ST_STALL;
          stall_cnt_d = 8'd1;
          if (MAX_STALL == 1) stall_timeout_d = 1'b1;
        end else begin
          stall_cnt_d = 8'd0;
        end
      end
      ST_STALL: begin
        if (freeze) begin
          stall_cnt_d = (stall_cnt_q == 8'hFF) ? 8'hFF : stall_cnt_inc[7:0];
          if (stall_cnt_inc == 9'(MAX_STALL)) stall_timeout_d = 1'b1;
        end else begin
          state_d     = ST_RUN;
          stall_cnt_d = 8'd0;
        end
      end
      default: begin
        state_d     = ST_RUN;
        stall_cnt_d = 8'd0;
      end
    endcase
    // Clearing the statistics also acknowledges the timeout, and wins over a new set.
    if (clr_stats) stall_timeout_d = 1'b0;
  end

  assign stall_timeout = stall_timeout_q;

  // Saturating activity counters; a clear in the same cycle wins over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      fwd_events_q   <= '0;
    end else if (clr_stats) begin
      stall_cycles_q <= '0;
      fwd_events_q   <= '0;
    end else begin
      if (freeze && (stall_cycles_q != 16'hFFFF)) stall_cycles_q <= stall_cycles_q + 16'd1;
      if ((|fwd_en) && (fwd_events_q != 16'hFFFF)) fwd_events_q <= fwd_events_q + 16'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign fwd_events   = fwd_events_q;

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// Self-checking bench for fwd_scoreboard_unit: directed cases with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model (writer priority list, retire history queue, plain counters).
module tb_fwd_scoreboard_unit;

  localparam int DATA_W    = 16;
  localparam int NREGS     = 8;
  localparam int AW        = 3;
  localparam int NRD       = 2;
  localparam int RET_DEPTH = 2;
  localparam int MAX_STALL = 15;
  localparam int ZERO_REG  = 1;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NRD-1:0]        rd_en;
  logic [NRD*AW-1:0]     rd_addr;
  logic                  ex_wr_en, ex_vld, mem_wr_en, mem_vld, wb_wr_en, clr_stats;
  logic [AW-1:0]         ex_dest, mem_dest, wb_dest;
  logic [DATA_W-1:0]     ex_data, mem_data, wb_data;
  logic [NRD*DATA_W-1:0] fwd_data;
  logic [NRD-1:0]        fwd_en;
  logic                  freeze, stall_timeout;
  logic [15:0]           stall_cycles, fwd_events;

  fwd_scoreboard_unit #(
    .DATA_W(DATA_W), .NREGS(NREGS), .NRD(NRD), .RET_DEPTH(RET_DEPTH),
    .MAX_STALL(MAX_STALL), .ZERO_REG(ZERO_REG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr),
    .ex_wr_en(ex_wr_en), .ex_dest(ex_dest), .ex_data(ex_data), .ex_vld(ex_vld),
    .mem_wr_en(mem_wr_en), .mem_dest(mem_dest), .mem_data(mem_data), .mem_vld(mem_vld),
    .wb_wr_en(wb_wr_en), .wb_dest(wb_dest), .wb_data(wb_data), .clr_stats(clr_stats),
    .fwd_data(fwd_data), .fwd_en(fwd_en), .freeze(freeze), .stall_timeout(stall_timeout),
    .stall_cycles(stall_cycles), .fwd_events(fwd_events)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [AW-1:0]     dest;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t ret_q[$];          // recent WB writes, index 0 = newest
  int  m_run;             // current consecutive freeze length
  int  m_stall_cycles;
  int  m_fwd_events;
  bit  m_timeout;

  logic [NRD-1:0]        m_fe;
  logic [NRD*DATA_W-1:0] m_fd;
  bit                    m_frz;

  function automatic void model_reset();
    ret_q.delete();
    m_run = 0; m_stall_cycles = 0; m_fwd_events = 0; m_timeout = 0;
  endfunction

  // Which value each port must see, from the writer list youngest first.
  function automatic void model_lookup(output logic [NRD-1:0] fe,
                                       output logic [NRD*DATA_W-1:0] fd,
                                       output bit frz);
    fe = '0; fd = '0; frz = 0;
    for (int i = 0; i < NRD; i++) begin
      logic [AW-1:0] a;
      a = rd_addr[i*AW +: AW];
      if (!rd_en[i]) continue;
      if (ZERO_REG != 0 && a == 0) continue;
      if (ex_wr_en && ex_dest == a) begin
        if (ex_vld) begin fe[i] = 1; fd[i*DATA_W +: DATA_W] = ex_data; end
        else frz = 1;
        continue;
      end
      if (mem_wr_en && mem_dest == a) begin
        if (mem_vld) begin fe[i] = 1; fd[i*DATA_W +: DATA_W] = mem_data; end
        else frz = 1;
        continue;
      end
      if (wb_wr_en && wb_dest == a) begin
        fe[i] = 1; fd[i*DATA_W +: DATA_W] = wb_data;
        continue;
      end
      foreach (ret_q[k]) begin
        if (ret_q[k].dest == a) begin
          fe[i] = 1; fd[i*DATA_W +: DATA_W] = ret_q[k].data;
          break;
        end
      end
    end
  endfunction

  // Compare all outputs against the model (called away from the rising edge).
  task automatic sample();
    @(negedge clk);
    model_lookup(m_fe, m_fd, m_frz);
    check("fwd_en", 32'(fwd_en), 32'(m_fe));
    for (int i = 0; i < NRD; i++)
      if (m_fe[i]) check($sformatf("fwd_data%0d", i), 32'(fwd_data[i*DATA_W +: DATA_W]),
                         32'(m_fd[i*DATA_W +: DATA_W]));
    check("freeze", 32'(freeze), 32'(m_frz));
    check("stall_timeout", 32'(stall_timeout), 32'(m_timeout));
    check("stall_cycles", 32'(stall_cycles), 32'(m_stall_cycles));
    check("fwd_events", 32'(fwd_events), 32'(m_fwd_events));
  endtask

  // Apply the coming clock edge to the model, then move past it.
  task automatic advance();
    int run_n;
    if (m_frz) begin
      run_n = m_run + 1;
      if (run_n == MAX_STALL) m_timeout = 1;
      m_run = (run_n > 255) ? 255 : run_n;
    end else begin
      m_run = 0;
    end
    if (clr_stats) begin
      m_stall_cycles = 0; m_fwd_events = 0; m_timeout = 0;
    end else begin
      if (m_frz && m_stall_cycles < 16'hFFFF) m_stall_cycles++;
      if (|m_fe && m_fwd_events < 16'hFFFF) m_fwd_events++;
    end
    if (wb_wr_en) begin
      ret_q.push_front('{dest: wb_dest, data: wb_data});
      if (ret_q.size() > RET_DEPTH) void'(ret_q.pop_back());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  task automatic idle();
    rd_en = '0; rd_addr = '0;
    ex_wr_en = 0; ex_dest = '0; ex_data = '0; ex_vld = 0;
    mem_wr_en = 0; mem_dest = '0; mem_data = '0; mem_vld = 0;
    wb_wr_en = 0; wb_dest = '0; wb_data = '0; clr_stats = 0;
  endtask

  task automatic wb_write(input logic [AW-1:0] d, input logic [DATA_W-1:0] v);
    idle();
    wb_wr_en = 1; wb_dest = d; wb_data = v;
    cycle();
  endtask

  task automatic read0(input logic [AW-1:0] a);
    idle();
    rd_en = 2'b01; rd_addr = {3'd0, a};
  endtask

  initial begin
    idle();
    rst_n = 0;
    model_reset();
    #12;
    check("rst_fwd_en", 32'(fwd_en), 0);
    check("rst_freeze", 32'(freeze), 0);
    check("rst_fwd_data", 32'(fwd_data), 0);
    check("rst_timeout", 32'(stall_timeout), 0);
    check("rst_stall_cycles", 32'(stall_cycles), 0);
    check("rst_fwd_events", 32'(fwd_events), 0);
    rst_n = 1;
    @(posedge clk); #1;

    // EX forward
    idle();
    ex_wr_en = 1; ex_dest = 3; ex_vld = 1; ex_data = 16'h00AA;
    rd_en = 2'b01; rd_addr = {3'd0, 3'd3};
    sample();
    check("t1_fwd_en0", 32'(fwd_en[0]), 1);
    check("t1_fwd_data0", 32'(fwd_data[15:0]), 32'h00AA);
    check("t1_freeze", 32'(freeze), 0);
    advance();

    // EX and MEM on the same dest: youngest (EX) wins
    idle();
    ex_wr_en = 1; ex_dest = 5; ex_vld = 1; ex_data = 16'h0011;
    mem_wr_en = 1; mem_dest = 5; mem_vld = 1; mem_data = 16'h0022;
    rd_en = 2'b10; rd_addr = {3'd5, 3'd0};
    sample();
    check("t2_fwd_en", 32'(fwd_en), 32'b10);
    check("t2_fwd_data1", 32'(fwd_data[31:16]), 32'h0011);
    advance();

    // Load in EX freezes; next cycle it is valid in MEM
    idle();
    ex_wr_en = 1; ex_dest = 2; ex_vld = 0; rd_en = 2'b01; rd_addr = {3'd0, 3'd2};
    sample();
    check("t3_freeze_load", 32'(freeze), 1);
    check("t3_fwd_en0", 32'(fwd_en[0]), 0);
    advance();
    idle();
    mem_wr_en = 1; mem_dest = 2; mem_vld = 1; mem_data = 16'h1234;
    rd_en = 2'b01; rd_addr = {3'd0, 3'd2};
    sample();
    check("t3_freeze_rel", 32'(freeze), 0);
    check("t3_fwd_data0", 32'(fwd_data[15:0]), 32'h1234);
    check("t3_stall_cycles", 32'(stall_cycles), 1);
    check("t3_fwd_events", 32'(fwd_events), 2);
    advance();

    // Retire buffer hit after WB
    wb_write(3'd4, 16'hBEEF);
    read0(3'd4);
    sample();
    check("t4_ret_hit_en", 32'(fwd_en[0]), 1);
    check("t4_ret_hit_data", 32'(fwd_data[15:0]), 32'hBEEF);
    advance();

    // Newest retire entry wins; entries age out after RET_DEPTH writes
    wb_write(3'd6, 16'h0A0A);
    wb_write(3'd6, 16'h0B0B);
    read0(3'd6);
    sample();
    check("t4_ret_newest", 32'(fwd_data[15:0]), 32'h0B0B);
    advance();
    read0(3'd4);
    sample();
    check("t4_ret_aged_out", 32'(fwd_en[0]), 0);
    advance();
    // Live WB write to the register being read forwards wb_data
    read0(3'd6);
    wb_wr_en = 1; wb_dest = 6; wb_data = 16'h0C0C;
    sample();
    check("t4_wb_live", 32'(fwd_data[15:0]), 32'h0C0C);
    advance();

    // Long stall: timeout after the 15th consecutive freeze cycle
    for (int c = 1; c <= 20; c++) begin
      idle();
      mem_wr_en = 1; mem_dest = 6; mem_vld = 0; rd_en = 2'b01; rd_addr = {3'd0, 3'd6};
      sample();
      check($sformatf("t5_timeout_c%0d", c), 32'(stall_timeout), (c >= 16) ? 1 : 0);
      advance();
    end
    idle();
    mem_wr_en = 1; mem_dest = 6; mem_vld = 1; mem_data = 16'h6060;
    rd_en = 2'b01; rd_addr = {3'd0, 3'd6}; clr_stats = 1;
    sample();
    check("t5_stall_cycles", 32'(stall_cycles), 21);
    advance();
    idle();
    sample();
    check("t5_clr_timeout", 32'(stall_timeout), 0);
    check("t5_clr_stall_cycles", 32'(stall_cycles), 0);
    check("t5_clr_fwd_events", 32'(fwd_events), 0);
    advance();

    // Reset in the middle of a stall
    idle();
    mem_wr_en = 1; mem_dest = 1; mem_vld = 0; rd_en = 2'b01; rd_addr = {3'd0, 3'd1};
    repeat (3) cycle();
    sample();
    #1 rst_n = 0;
    #1;
    check("t6_rst_stall_cycles", 32'(stall_cycles), 0);
    check("t6_rst_fwd_events", 32'(fwd_events), 0);
    check("t6_rst_freeze_live", 32'(freeze), 1);
    model_reset();
    #1 rst_n = 1;
    advance();
    cycle();

    // Hardwired r0: never forwarded, never stalled on
    idle();
    ex_wr_en = 1; ex_dest = 0; ex_vld = 0; rd_en = 2'b01; rd_addr = {3'd0, 3'd0};
    sample();
    check("t7_zero_fwd_en", 32'(fwd_en), 0);
    check("t7_zero_freeze", 32'(freeze), 0);
    advance();

    // Randomized traffic, narrow register range to provoke matches
    for (int n = 0; n < 800; n++) begin
      rd_en     = NRD'($urandom);
      rd_addr   = (n < 400) ? (NRD*AW)'($urandom) : (NRD*AW)'($urandom & 32'h1B);
      ex_wr_en  = ($urandom_range(0, 2) != 0);
      ex_dest   = (n < 400) ? AW'($urandom) : AW'($urandom_range(0, 3));
      ex_data   = DATA_W'($urandom);
      ex_vld    = ($urandom_range(0, 3) != 0);
      mem_wr_en = ($urandom_range(0, 2) != 0);
      mem_dest  = (n < 400) ? AW'($urandom) : AW'($urandom_range(0, 3));
      mem_data  = DATA_W'($urandom);
      mem_vld   = ($urandom_range(0, 4) != 0);
      wb_wr_en  = ($urandom_range(0, 1) != 0);
      wb_dest   = (n < 400) ? AW'($urandom) : AW'($urandom_range(0, 3));
      wb_data   = DATA_W'($urandom);
      clr_stats = ($urandom_range(0, 40) == 0);
      cycle();
    end

    // Sustained random stall run to exercise timeout under random reads
    idle();
    mem_wr_en = 1; mem_dest = 7; mem_vld = 0; rd_en = 2'b11; rd_addr = {3'd7, 3'd5};
    repeat (18) cycle();
    idle();
    repeat (2) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
